// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction fetch and data ports.
// Define MEM_ARB_FAIR_EN to add the fetch-fairness burst counter (strict data priority otherwise).
module mem_port_arbiter #(
   parameter int unsigned MAX_D_BURST    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_stall,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        timeout
);
   localparam int unsigned WD_W    = 8;
   localparam int unsigned BURST_W = 4;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   if (MAX_D_BURST < 1 || MAX_D_BURST > 15) begin : g_bad_burst
      $error("MAX_D_BURST must be in 1..15");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

   state_t          state;
   logic [WD_W-1:0] wd_cnt;

   logic d_pend;
   logic busy;
   logic expire;
   logic if_done;
   logic d_done;
   logic fair_force;
   logic grant_d;
   logic grant_if;

   assign d_pend   = d_read | d_write;
   assign busy     = (state != IDLE);
   // Watchdog fires on the last allowed busy cycle so the stall releases in that same cycle.
   assign expire   = busy && !mem_ack && (wd_cnt == WD_LAST);
   assign if_done  = (state == IF_BUSY) && (mem_ack || expire);
   assign d_done   = (state == D_BUSY) && (mem_ack || expire);
   assign grant_d  = (state == IDLE) && d_pend && !fair_force;
   assign grant_if = (state == IDLE) && if_req && (!d_pend || fair_force);

   assign if_stall = if_req && !if_done;
   assign d_stall  = d_pend && !d_done;
   assign if_rdata = expire ? 32'h0 : mem_rdata;
   assign d_rdata  = expire ? 32'h0 : mem_rdata;

`ifdef MEM_ARB_FAIR_EN
   logic [BURST_W-1:0] burst_cnt;

   // Counts data grants taken while a fetch waits; a full burst forces one fetch grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         burst_cnt <= '0;
      end else if (grant_if) begin
         burst_cnt <= '0;
      end else if (grant_d && if_req) begin
         burst_cnt <= burst_cnt + BURST_W'(1);
      end
   end

   assign fair_force = if_req && (burst_cnt == BURST_W'(MAX_D_BURST));
`else
   assign fair_force = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         timeout   <= 1'b0;
         wd_cnt    <= '0;
      end else begin
         timeout <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant_d) begin
                  state     <= D_BUSY;
                  mem_req   <= 1'b1;
                  mem_we    <= d_write;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  wd_cnt    <= '0;
               end else if (grant_if) begin
                  state    <= IF_BUSY;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= if_addr;
                  wd_cnt   <= '0;
               end
            end
            IF_BUSY, D_BUSY: begin
               if (mem_ack || expire) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  timeout <= expire;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, memory responder, grant/completion monitor.
module tb_mem_port_arbiter;
   localparam int unsigned TO_CYC = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_stall;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        timeout;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } grant_t;

   typedef struct {
      bit          port_d;
      logic [31:0] data;
      bit          chk;
   } cpl_t;

   grant_t exp_g[$];
   cpl_t   exp_c[$];
   int     n_vec = 0;
   int     n_err = 0;
   int     to_cnt = 0;
   int     lat = 0;
   bit     never_ack = 1'b0;
   bit     spur_ack = 1'b0;

   mem_port_arbiter #(.MAX_D_BURST(4), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_stall(d_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout(timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      logic [15:0] lo;
      lo = a[15:0];
      return (a == 32'h100) ? 32'hDEADBEEF : {lo, ~lo};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push_g(input bit we, input logic [31:0] a, input logic [31:0] wd);
      grant_t g;
      g.we = we; g.addr = a; g.wdata = wd;
      exp_g.push_back(g);
   endtask

   task automatic push_c(input bit pd, input logic [31:0] dat, input bit chk);
      cpl_t c;
      c.port_d = pd; c.data = dat; c.chk = chk;
      exp_c.push_back(c);
   endtask

   task automatic do_cpl(input bit pd, input logic [31:0] dat);
      cpl_t c;
      if (exp_c.size() == 0) begin
         n_vec++; n_err++;
         $display("FAIL cpl_unexpected: port_d %0d completed, none expected", pd);
      end else begin
         c = exp_c.pop_front();
         check("cpl_port", 32'(pd), 32'(c.port_d));
         if (c.chk) check(pd ? "d_rdata" : "if_rdata", dat, c.data);
      end
   endtask

   // Memory model: ack lat cycles after the first busy cycle; optional spurious ack while idle.
   initial begin
      int age;
      age = 0;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (mem_req) age++; else age = 0;
         if (mem_req && !never_ack && age == lat + 1) begin
            mem_ack = 1'b1; mem_rdata = mem_fn(mem_addr);
         end else if (!mem_req && spur_ack) begin
            mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
         end else begin
            mem_ack = 1'b0; mem_rdata = 32'hBADBAD00;
         end
      end
   end

   // Monitor: pops expected grants on mem_req rise and expected completions on stall release.
   initial begin
      grant_t g;
      logic   prev_req;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (mem_req && !prev_req) begin
            if (exp_g.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL grant_unexpected: got addr 0x%08h, none expected", mem_addr);
            end else begin
               g = exp_g.pop_front();
               check("grant_we", 32'(mem_we), 32'(g.we));
               check("grant_addr", mem_addr, g.addr);
               if (g.we) check("grant_wdata", mem_wdata, g.wdata);
            end
         end
         prev_req = mem_req;
         if (if_req && !if_stall) do_cpl(1'b0, if_rdata);
         if ((d_read || d_write) && !d_stall) do_cpl(1'b1, d_rdata);
         if (timeout) to_cnt++;
      end
   end

   // Runs until all raised requests finish; counts stall-high and mem_req-high cycles.
   task automatic serve(output int ifc, output int dc, output int rc);
      bit idn, ddn;
      ifc = 0; dc = 0; rc = 0;
      for (int c = 0; c < 400; c++) begin
         #1;
         idn = 1'b0; ddn = 1'b0;
         if (mem_req) rc++;
         if (if_req) begin
            if (if_stall) ifc++; else idn = 1'b1;
         end
         if (d_read || d_write) begin
            if (d_stall) dc++; else ddn = 1'b1;
         end
         @(negedge clk);
         if (idn) if_req = 1'b0;
         if (ddn) begin d_read = 1'b0; d_write = 1'b0; end
         if (!if_req && !d_read && !d_write) return;
      end
      n_vec++; n_err++;
      $display("FAIL serve_bound: requests still pending after 400 cycles");
   endtask

   initial begin
      #200000;
      $display("FAIL global_bound: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  ifc, dc, rc, to0, nd;
      bit  ifdone, dd, idd;
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;

      repeat (2) @(negedge clk);
      #1;
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_if_stall", 32'(if_stall), 32'd0);
      check("rst_d_stall", 32'(d_stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single fetch, ack on first busy cycle
      lat = 0;
      @(negedge clk);
      if_addr = 32'h100; if_req = 1'b1;
      push_g(1'b0, 32'h100, 32'h0);
      push_c(1'b0, 32'hDEADBEEF, 1'b1);
      serve(ifc, dc, rc);
      check("t1_if_stall_cycles", 32'(ifc), 32'd1);
      check("t1_mem_req_cycles", 32'(rc), 32'd1);

      // Concurrent fetch and store, latency 3: store first
      lat = 3;
      @(negedge clk);
      if_addr = 32'h200; if_req = 1'b1;
      d_addr = 32'h80; d_wdata = 32'h12345678; d_write = 1'b1;
      push_g(1'b1, 32'h80, 32'h12345678);
      push_g(1'b0, 32'h200, 32'h0);
      push_c(1'b1, 32'h0, 1'b0);
      push_c(1'b0, mem_fn(32'h200), 1'b1);
      serve(ifc, dc, rc);
      check("t2_d_stall_cycles", 32'(dc), 32'd4);
      check("t2_if_stall_cycles", 32'(ifc), 32'd9);
      check("t2_mem_req_cycles", 32'(rc), 32'd8);

      // Fairness: continuous loads with a waiting fetch
      lat = 0;
      @(negedge clk);
      if_addr = 32'h300; if_req = 1'b1;
      d_addr = 32'h1000; d_read = 1'b1;
`ifdef MEM_ARB_FAIR_EN
      for (int i = 0; i < 4; i++) begin
         push_g(1'b0, 32'h1000 + 32'(4 * i), 32'h0);
         push_c(1'b1, mem_fn(32'h1000 + 32'(4 * i)), 1'b1);
      end
      push_g(1'b0, 32'h300, 32'h0);
      push_c(1'b0, mem_fn(32'h300), 1'b1);
      push_g(1'b0, 32'h1010, 32'h0);
      push_c(1'b1, mem_fn(32'h1010), 1'b1);
`else
      for (int i = 0; i < 5; i++) begin
         push_g(1'b0, 32'h1000 + 32'(4 * i), 32'h0);
         push_c(1'b1, mem_fn(32'h1000 + 32'(4 * i)), 1'b1);
      end
      push_g(1'b0, 32'h300, 32'h0);
      push_c(1'b0, mem_fn(32'h300), 1'b1);
`endif
      nd = 0; ifdone = 1'b0;
      for (int c = 0; c < 200 && !(nd == 5 && ifdone); c++) begin
         #1;
         dd  = d_read && !d_stall;
         idd = if_req && !if_stall;
         @(negedge clk);
         if (idd) begin if_req = 1'b0; ifdone = 1'b1; end
         if (dd) begin
            nd++;
            if (nd == 5) d_read = 1'b0; else d_addr = d_addr + 32'h4;
         end
      end
      check("t3_loads_done", 32'(nd), 32'd5);
      check("t3_fetch_done", 32'(ifdone), 32'd1);

      // Watchdog abort of a load
      never_ack = 1'b1;
      @(negedge clk);
      to0 = to_cnt;
      d_addr = 32'h40; d_read = 1'b1;
      push_g(1'b0, 32'h40, 32'h0);
      push_c(1'b1, 32'h0, 1'b1);
      serve(ifc, dc, rc);
      check("t4_d_stall_cycles", 32'(dc), 32'd10);
      check("t4_mem_req_cycles", 32'(rc), 32'd10);
      repeat (3) @(negedge clk);
      check("t4_timeout_pulses", 32'(to_cnt - to0), 32'd1);

      // Reset in the middle of a store
      d_addr = 32'h500; d_wdata = 32'hCAFEF00D; d_write = 1'b1;
      push_g(1'b1, 32'h500, 32'hCAFEF00D);
      repeat (3) @(negedge clk);
      #1;
      check("t5_busy_mem_we", 32'(mem_we), 32'd1);
      #2;
      rst = 1'b1;
      d_write = 1'b0;
      if_addr = 32'h600; if_req = 1'b1;
      never_ack = 1'b0; lat = 1;
      #1;
      check("t5_async_mem_req", 32'(mem_req), 32'd0);
      check("t5_async_mem_we", 32'(mem_we), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      push_g(1'b0, 32'h600, 32'h0);
      push_c(1'b0, mem_fn(32'h600), 1'b1);
      serve(ifc, dc, rc);
      check("t5_if_stall_cycles", 32'(ifc), 32'd2);

      // Spurious ack while idle, then address change mid-access
      @(negedge clk);
      #3 spur_ack = 1'b1;
      @(negedge clk);
      #3 spur_ack = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("t6_idle_ack_mem_req", 32'(mem_req), 32'd0);
      check("t6_idle_ack_mem_addr", mem_addr, 32'h600);
      lat = 2;
      @(negedge clk);
      d_addr = 32'h700; d_read = 1'b1;
      push_g(1'b0, 32'h700, 32'h0);
      push_c(1'b1, mem_fn(32'h700), 1'b1);
      @(negedge clk);
      d_addr = 32'h7FC;
      #1;
      check("t6_latched_addr", mem_addr, 32'h700);
      serve(ifc, dc, rc);
      check("t6_d_stall_cycles", 32'(dc), 32'd2);

      repeat (3) @(negedge clk);
      check("grants_left", 32'(exp_g.size()), 32'd0);
      check("cpls_left", 32'(exp_c.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, variable-latency memory between the CPU's instruction-fetch port and data (load/store) port. Sits between `cpu` and memory: accepts concurrent requests, serialises them through a three-state FSM, and drives per-port stall signals that freeze the pipeline until that port's access completes. Includes a fairness counter so fetch cannot be starved, and a watchdog that aborts an access whose acknowledge never arrives.

## Interface
- `MAX_D_BURST`, 4: consecutive data grants allowed while a fetch waits (range 1–15).
- `TIMEOUT_CYCLES`, 255: cycles in a busy state without `mem_ack` before abort (range 1–255).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `if_req` in 1: fetch request; held until stall drops.
- `if_addr` in 32: fetch address.
- `if_rdata` out 32: fetched word; valid when `if_req && !if_stall`.
- `if_stall` out 1: fetch not yet complete.
- `d_read` in 1: load request.
- `d_write` in 1: store request; wins if `d_read` is also high.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: load word; valid when `d_read && !d_stall`.
- `d_stall` out 1: data access not yet complete.
- `mem_req` out 1: registered memory request.
- `mem_we` out 1: registered write enable.
- `mem_addr` out 32: registered address.
- `mem_wdata` out 32: registered write data.
- `mem_rdata` in 32: memory read data; valid with `mem_ack`.
- `mem_ack` in 1: one-cycle completion pulse from memory.
- `timeout` out 1: one-cycle registered pulse when the watchdog aborts an access.

## Operation
- FSM states: IDLE, IF_BUSY, D_BUSY.
- IDLE: data request pending (`d_read|d_write`) → D_BUSY; else `if_req` → IF_BUSY; else stay. Fairness override below can select IF_BUSY instead.
- On entry to a busy state: latch address, write data (data port only) and `mem_we` (1 only for `d_write`); assert `mem_req`.
- Busy state with `mem_ack`: deassert `mem_req`/`mem_we`, return to IDLE. Requester inputs are ignored while busy; the latched copy is used.
- Stalls (combinational): `if_stall = if_req && !(state==IF_BUSY && mem_ack)`; `d_stall = (d_read|d_write) && !(state==D_BUSY && mem_ack)`.
- `if_rdata`/`d_rdata` = `mem_rdata` passed through; the requester captures it on the ack cycle.
- `mem_ack` in IDLE is ignored.
- Watchdog: an 8-bit counter clears on busy-state entry and increments each busy cycle without ack. Reaching `TIMEOUT_CYCLES` → return to IDLE, drop `mem_req`, pulse `timeout`, and release that port's stall for one cycle with read data forced to 0. A store aborted this way is lost.
- Reset mid-access: FSM goes to IDLE immediately; outstanding access is abandoned.

## Timing
- Reset values: `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `timeout` 0, FSM IDLE, burst and watchdog counters 0. Stalls follow their combinational equations.
- Request seen in IDLE at edge N → `mem_req` high after edge N.
- Minimum access takes 2 cycles: ack during the first busy cycle releases the stall in that same cycle.
- Back-to-back: the FSM is in IDLE for one cycle between accesses, so the next `mem_req` rises 2 edges after the previous ack edge.
- Simultaneous fetch and data requests: data is served first and fetch stays stalled through the data access plus IDLE, then is granted.

## Configuration
- `MEM_ARB_FAIR_EN` defined:
  - A 4-bit counter increments on each D_BUSY grant made while `if_req` is high.
  - When it equals `MAX_D_BURST`, IDLE grants the fetch even if data is pending, and the counter clears.
  - The counter also clears on any IF_BUSY grant.
- Not defined: strict data priority; counter logic is absent.

## Test plan
- Single fetch, `if_addr`=0x100, `mem_ack` on the first busy cycle, `mem_rdata`=0xDEADBEEF → `mem_req` for 1 cycle with `mem_addr`=0x100; `if_stall` drops on the ack cycle with `if_rdata`=0xDEADBEEF.
- Simultaneous `if_req` (0x200) and `d_write` (0x80, data 0x12345678), memory latency 3 → store issued first with `mem_we`=1 and `d_stall` high for 4 cycles; fetch issued after 1 IDLE cycle; `if_stall` high for 9 cycles.
- Fairness, `MAX_D_BURST`=4, continuous `d_read` and `if_req` → with `MEM_ARB_FAIR_EN`: grant order D,D,D,D,IF,D,…; without it: fetch is never granted.
- Memory never acks, `TIMEOUT_CYCLES`=10 → `mem_req` drops after 10 busy cycles; `timeout` pulses once; `d_stall` low for 1 cycle with `d_rdata`=0.
- `rst` asserted mid-D_BUSY → `mem_req`/`mem_we` low asynchronously; after release, a pending `if_req` is granted from IDLE normally.
- `mem_ack` pulsed while IDLE and `d_addr` changed mid-access → no state change; `mem_addr` keeps the latched value.
